// File: rtl/ic_74148_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ic_74148_pkg
// Purpose : Shared types, constants and helpers for the latched 74148-style
//           8-to-3 priority encoder.
// Contents: state_t  - handshake FSM states (IDLE, HOLD, RELEASE)
//           N_REQ    - number of request lines (8)
//           CODE_W   - width of the encoded index (3)
//           highest_low_idx() - index of the highest-numbered low bit
// Revision: 1.0 - initial release
// ============================================================================
package ic_74148_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Scans upward so the last hit wins: the highest-numbered low bit has
  // priority. Returns 0 for an all-high vector; callers qualify separately.
  function automatic logic [CODE_W-1:0] highest_low_idx(input logic [N_REQ-1:0] req_n);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!req_n[k]) idx = CODE_W'(k);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module  : sync_ff
// Purpose : Multi-flop synchroniser for asynchronous inputs. All stages
//           reset to ones so active-low inputs read as inactive out of reset.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           d     - asynchronous input vector [WIDTH-1:0]
//           q     - synchronised output, SYNC_STAGES clocks behind d
// Revision: 1.0 - initial release
// ============================================================================
module sync_ff #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) stage[k] <= '1;
    end else begin
      stage[0] <= d;
      for (int k = 1; k < SYNC_STAGES; k++) stage[k] <= stage[k-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ic_74148_latched.sv
`default_nettype none
// ============================================================================
// Module  : ic_74148_latched
// Purpose : Registered 8-to-3 priority encoder with 74148-style active-low
//           pins. Synchronises the request/enable lines, latches the code of
//           the highest active request and offers it with a valid/ack
//           handshake. After ack it waits for the captured line to release
//           before re-arming. gs_n/eo_n are registered for cascading.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           ei_n  - enable input, active-low, asynchronous
//           i_n   - request lines [7:0], active-low, asynchronous, 7 highest
//           ack   - consumer acknowledge, level-sampled
//           a_n   - latched code [2:0], active-low
//           valid - a_n holds an unacknowledged code
//           gs_n  - group select (enabled and some request low)
//           eo_n  - enable output (enabled and no request low)
// Options : define IC_74148_DEBOUNCE_EN to require the synchronised request
//           vector to be stable for DEB_CYCLES edges before capture.
// Revision: 1.0 - initial release
// ============================================================================
module ic_74148_latched
  import ic_74148_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ei_n,
  input  logic [N_REQ-1:0]  i_n,
  input  logic              ack,
  output logic [CODE_W-1:0] a_n,
  output logic              valid,
  output logic              gs_n,
  output logic              eo_n
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEB_CYCLES < 1) begin : g_param_check
    $error("ic_74148_latched: SYNC_STAGES must be 2..4 and DEB_CYCLES >= 1");
  end

  // Enable and requests share one synchroniser so they stay cycle-aligned.
  logic [N_REQ:0]     sync_q;
  logic               s_ei_n;
  logic [N_REQ-1:0]   s_i_n;

  sync_ff #(
    .WIDTH       (N_REQ + 1),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({ei_n, i_n}),
    .q     (sync_q)
  );

  assign s_ei_n = sync_q[N_REQ];
  assign s_i_n  = sync_q[N_REQ-1:0];

  logic any_req;
  logic qualify;
  logic capture_ok;

  assign any_req = (s_i_n != '1);
  assign qualify = !s_ei_n && any_req;

`ifdef IC_74148_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

  logic [N_REQ-1:0] prev_i_n;
  logic [CNT_W-1:0] deb_cnt;

  // Counter restarts on any change of the vector or loss of qualification
  // and saturates at DEB_CYCLES; capture waits for saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_i_n <= '1;
      deb_cnt  <= '0;
    end else begin
      prev_i_n <= s_i_n;
      if (!qualify || (s_i_n != prev_i_n)) deb_cnt <= '0;
      else if (deb_cnt != CNT_MAX)         deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign capture_ok = qualify && (deb_cnt == CNT_MAX);
`else
  assign capture_ok = qualify;
`endif

  // Cascade outputs follow the synchronised inputs every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gs_n <= 1'b1;
      eo_n <= 1'b1;
    end else begin
      gs_n <= !(!s_ei_n && any_req);
      eo_n <= !(!s_ei_n && !any_req);
    end
  end

  // Handshake FSM
  state_t              state, state_next;
  logic [CODE_W-1:0]   cap_idx, cap_idx_next;
  logic [CODE_W-1:0]   a_n_next;
  logic                valid_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cap_idx <= '0;
      a_n     <= '1;
      valid   <= 1'b0;
    end else begin
      state   <= state_next;
      cap_idx <= cap_idx_next;
      a_n     <= a_n_next;
      valid   <= valid_next;
    end
  end

  always_comb begin
    state_next   = state;
    cap_idx_next = cap_idx;
    a_n_next     = a_n;
    valid_next   = valid;
    case (state)
      IDLE: begin
        if (capture_ok) begin
          cap_idx_next = highest_low_idx(s_i_n);
          a_n_next     = ~cap_idx_next;
          valid_next   = 1'b1;
          state_next   = HOLD;
        end
      end
      HOLD: begin
        // Losing the enable outranks an acknowledge in the same cycle.
        if (s_ei_n) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end else if (ack) begin
          valid_next = 1'b0;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        // Re-arm only once the captured line itself has gone inactive, so a
        // held request is not reported twice.
        if (s_ei_n || s_i_n[cap_idx]) state_next = IDLE;
      end
      default: begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ic_74148_latched.sv
`default_nettype none
// ============================================================================
// Module  : tb_ic_74148_latched
// Purpose : Self-checking bench for ic_74148_latched (default build). A
//           driver applies directed and random stimulus and a reference
//           model pushes the expected outputs per clock into a queue; a
//           monitor pops and compares on the falling edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ic_74148_latched;

  localparam int SYNC_STAGES = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ei_n  = 1'b0;
  logic [7:0] i_n   = 8'h00;
  logic       ack   = 1'b0;
  logic [2:0] a_n;
  logic       valid;
  logic       gs_n;
  logic       eo_n;

  ic_74148_latched #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ei_n  (ei_n),
    .i_n   (i_n),
    .ack   (ack),
    .a_n   (a_n),
    .valid (valid),
    .gs_n  (gs_n),
    .eo_n  (eo_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] a_n;
    logic       valid;
    logic       gs_n;
    logic       eo_n;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // ---------------- reference model ----------------
  // Input delay line of SYNC_STAGES samples; 'waiting' modes:
  // 0 = free to capture, 1 = code offered, 2 = acked, waiting for release.
  logic [8:0] pipe[$];
  int         mode;
  int         cap;
  logic [2:0] m_a;
  logic       m_v, m_gs, m_eo;

  function automatic void model_reset();
    pipe.delete();
    for (int k = 0; k < SYNC_STAGES; k++) pipe.push_back(9'h1FF);
    mode = 0;
    cap  = 0;
    m_a  = 3'b111;
    m_v  = 1'b0;
    m_gs = 1'b1;
    m_eo = 1'b1;
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.a_n   = m_a;
    e.valid = m_v;
    e.gs_n  = m_gs;
    e.eo_n  = m_eo;
    return e;
  endfunction

  // Called at each rising edge with the inputs that were stable before it.
  function automatic void model_edge();
    logic [8:0] s;
    logic       s_ei;
    logic [7:0] s_i;
    if (!rst_n) begin
      model_reset();
    end else begin
      s    = pipe.pop_front();
      pipe.push_back({ei_n, i_n});
      s_ei = s[8];
      s_i  = s[7:0];
      m_gs = !(!s_ei && s_i != 8'hFF);
      m_eo = !(!s_ei && s_i == 8'hFF);
      if (mode == 0) begin
        if (!s_ei && s_i != 8'hFF) begin
          for (int k = 7; k >= 0; k--) begin
            if (!s_i[k]) begin
              cap = k;
              break;
            end
          end
          m_a  = 3'(7 - cap);
          m_v  = 1'b1;
          mode = 1;
        end
      end else if (mode == 1) begin
        if (s_ei) begin
          m_v  = 1'b0;
          mode = 0;
        end else if (ack) begin
          m_v  = 1'b0;
          mode = 2;
        end
      end else begin
        if (s_ei || s_i[cap]) mode = 0;
      end
    end
    exp_q.push_back(cur_exp());
  endfunction

  // ---------------- monitor ----------------
  function automatic void check(string name, logic [2:0] act, logic [2:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("valid", {2'b0, valid}, {2'b0, e.valid});
      check("gs_n",  {2'b0, gs_n},  {2'b0, e.gs_n});
      check("eo_n",  {2'b0, eo_n},  {2'b0, e.eo_n});
      check("a_n",   a_n,           e.a_n);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic [7:0] iv, input logic ev, input logic av, input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      i_n  = iv;
      ei_n = ev;
      ack  = av;
    end
  endtask

  // Asserts reset between edges, holds it for hold_cycles edges, then
  // releases it just after an edge.
  task automatic reset_pulse(input int hold_cycles);
    @(posedge clk);
    model_edge();
    #2;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    model_reset();
    exp_q.push_back(cur_exp());
    repeat (hold_cycles) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    // Reset with all requests active and enable low: outputs stay at reset.
    repeat (3) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    rst_n = 1'b1;
    i_n   = 8'hFF;
    ei_n  = 1'b0;
    step(8'hFF, 1'b0, 1'b0, 4);

    // Priority: lines 6,4,2 -> code 001; higher request in HOLD ignored.
    step(8'hAB, 1'b0, 1'b0, 4);
    step(8'h7F, 1'b0, 1'b0, 3);
    // Ack with line 6 held low: no recapture until it releases.
    step(8'hBF, 1'b0, 1'b1, 1);
    step(8'hBF, 1'b0, 1'b0, 5);
    step(8'hFF, 1'b0, 1'b0, 3);
    step(8'hFE, 1'b0, 1'b0, 4);
    step(8'hFE, 1'b0, 1'b1, 1);
    step(8'hFF, 1'b0, 1'b0, 4);

    // Enable dropped during HOLD, then requests while disabled.
    step(8'hEF, 1'b0, 1'b0, 4);
    step(8'hEF, 1'b1, 1'b0, 5);
    step(8'h00, 1'b1, 1'b1, 5);
    step(8'hFF, 1'b0, 1'b0, 4);

    // Mid-operation reset while valid, then ack with nothing captured.
    step(8'hF7, 1'b0, 1'b0, 4);
    reset_pulse(2);
    step(8'hFF, 1'b0, 1'b1, 4);
    step(8'hFF, 1'b0, 1'b0, 2);

    // Random segments.
    for (int seg = 0; seg < 200; seg++) begin
      logic [7:0] iv;
      iv = 8'hFF;
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(99) < 15) iv[b] = 1'b0;
      end
      if ($urandom_range(99) < 2) begin
        reset_pulse($urandom_range(1, 2));
      end else begin
        step(iv, ($urandom_range(99) < 10), ($urandom_range(99) < 30),
             $urandom_range(1, 6));
      end
    end

    step(8'hFF, 1'b0, 1'b0, 4);
    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
